mc_ctrl_fsm: RTL and testbench

//  Multi-cycle successor to the single-cycle decoder: same MIPS subset, decoded into per-phase strobes.

---
 rtl/mc_ctrl_fsm_pkg.sv | 93 +++++++++
 rtl/mc_ctrl_decode.sv | 81 ++++++++
 rtl/mc_ctrl_fsm.sv | 196 +++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_fsm_pkg
//  Brief    : Shared encodings for the multi-cycle MIPS-subset control unit.
//  Revision : 1.0  initial release
// ============================================================================
package mc_ctrl_fsm_pkg;

    localparam int c_TIMEOUT_W = 8;
    localparam int c_ALUOP_W   = 5;

    // ALU operation codes; EQL/BNE make the ALU's zero flag mean "take branch"
    localparam logic [c_ALUOP_W-1:0] c_ALUOP_NOP  = 5'd0;
    localparam logic [c_ALUOP_W-1:0] c_ALUOP_ADDU = 5'd1;
    localparam logic [c_ALUOP_W-1:0] c_ALUOP_ADD  = 5'd2;
    localparam logic [c_ALUOP_W-1:0] c_ALUOP_SUBU = 5'd3;
    localparam logic [c_ALUOP_W-1:0] c_ALUOP_SUB  = 5'd4;
    localparam logic [c_ALUOP_W-1:0] c_ALUOP_AND  = 5'd5;
    localparam logic [c_ALUOP_W-1:0] c_ALUOP_OR   = 5'd6;
    localparam logic [c_ALUOP_W-1:0] c_ALUOP_SLT  = 5'd7;
    localparam logic [c_ALUOP_W-1:0] c_ALUOP_EQL  = 5'd8;
    localparam logic [c_ALUOP_W-1:0] c_ALUOP_BNE  = 5'd9;
    localparam logic [c_ALUOP_W-1:0] c_ALUOP_SLL  = 5'd10;
    localparam logic [c_ALUOP_W-1:0] c_ALUOP_SRL  = 5'd11;
    localparam logic [c_ALUOP_W-1:0] c_ALUOP_SRA  = 5'd12;
    localparam logic [c_ALUOP_W-1:0] c_ALUOP_LUI  = 5'd13;

    localparam logic c_CAUSE_ILLEGAL = 1'b0;
    localparam logic c_CAUSE_TIMEOUT = 1'b1;

    localparam logic [1:0] c_PCSEL_SEQ  = 2'b00;
    localparam logic [1:0] c_PCSEL_BR   = 2'b01;
    localparam logic [1:0] c_PCSEL_RS   = 2'b10;
    localparam logic [1:0] c_PCSEL_JT   = 2'b11;
    localparam logic [1:0] c_REGDST_RT  = 2'b00;
    localparam logic [1:0] c_REGDST_RD  = 2'b01;
    localparam logic [1:0] c_REGDST_RA  = 2'b10;
    localparam logic [1:0] c_WD_ALU     = 2'b00;
    localparam logic [1:0] c_WD_MDR     = 2'b01;
    localparam logic [1:0] c_WD_PC      = 2'b10;
    localparam logic [1:0] c_SRCB_B     = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_SRCB_IMM   = 2'b10;
    localparam logic [1:0] c_SRCB_IMMSH = 2'b11;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [5:0] c_FN_SLL  = 6'b000000;
    localparam logic [5:0] c_FN_SRL  = 6'b000010;
    localparam logic [5:0] c_FN_SRA  = 6'b000011;
    localparam logic [5:0] c_FN_JR   = 6'b001000;
    localparam logic [5:0] c_FN_ADD  = 6'b100000;
    localparam logic [5:0] c_FN_ADDU = 6'b100001;
    localparam logic [5:0] c_FN_SUB  = 6'b100010;
    localparam logic [5:0] c_FN_SUBU = 6'b100011;
    localparam logic [5:0] c_FN_AND  = 6'b100100;
    localparam logic [5:0] c_FN_OR   = 6'b100101;
    localparam logic [5:0] c_FN_SLT  = 6'b101010;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_R_ALU   = 4'd1,
        CLS_I_ALU   = 4'd2,
        CLS_LOAD    = 4'd3,
        CLS_STORE   = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_JUMP    = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JR      = 4'd8
    } inst_class_e;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_decode
//  Brief    : Combinational instruction-class and ALU-field decode.
//  Revision : 1.0  initial release
// ============================================================================
module mc_ctrl_decode
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int EN_JAL = 1
) (
    input  logic [5:0]           i_opcode,
    input  logic [5:0]           i_func,
    output inst_class_e          o_class,
    output logic [c_ALUOP_W-1:0] o_alu_op,
    output logic [1:0]           o_alu_srcb,
    output logic                 o_ext_op
);

    always_comb begin
        o_class    = CLS_ILLEGAL;
        o_alu_op   = c_ALUOP_NOP;
        o_alu_srcb = c_SRCB_B;
        o_ext_op   = 1'b0;
        case (i_opcode)
            c_OP_RTYPE: begin
                o_class = CLS_R_ALU;
                case (i_func)
                    c_FN_ADDU: o_alu_op = c_ALUOP_ADDU;
                    c_FN_SUBU: o_alu_op = c_ALUOP_SUBU;
                    c_FN_ADD:  o_alu_op = c_ALUOP_ADD;
                    c_FN_SUB:  o_alu_op = c_ALUOP_SUB;
                    c_FN_AND:  o_alu_op = c_ALUOP_AND;
                    c_FN_OR:   o_alu_op = c_ALUOP_OR;
                    c_FN_SLL:  o_alu_op = c_ALUOP_SLL;
                    c_FN_SRL:  o_alu_op = c_ALUOP_SRL;
                    c_FN_SRA:  o_alu_op = c_ALUOP_SRA;
                    c_FN_SLT:  o_alu_op = c_ALUOP_SLT;
                    c_FN_JR:   o_class  = CLS_JR;
                    default:   o_class  = CLS_ILLEGAL;
                endcase
            end
            c_OP_ADDI: begin
                o_class = CLS_I_ALU; o_alu_op = c_ALUOP_ADD;
                o_alu_srcb = c_SRCB_IMM; o_ext_op = 1'b1;
            end
            c_OP_ORI: begin
                o_class = CLS_I_ALU; o_alu_op = c_ALUOP_OR;
                o_alu_srcb = c_SRCB_IMM;
            end
            c_OP_SLTI: begin
                o_class = CLS_I_ALU; o_alu_op = c_ALUOP_SLT;
                o_alu_srcb = c_SRCB_IMM; o_ext_op = 1'b1;
            end
            c_OP_LUI: begin
                o_class = CLS_I_ALU; o_alu_op = c_ALUOP_LUI;
                o_alu_srcb = c_SRCB_IMM;
            end
            c_OP_LW: begin
                o_class = CLS_LOAD; o_alu_op = c_ALUOP_ADDU;
                o_alu_srcb = c_SRCB_IMM; o_ext_op = 1'b1;
            end
            c_OP_SW: begin
                o_class = CLS_STORE; o_alu_op = c_ALUOP_ADDU;
                o_alu_srcb = c_SRCB_IMM; o_ext_op = 1'b1;
            end
            c_OP_BEQ: begin
                o_class = CLS_BRANCH; o_alu_op = c_ALUOP_EQL; o_ext_op = 1'b1;
            end
            c_OP_BNE: begin
                o_class = CLS_BRANCH; o_alu_op = c_ALUOP_BNE; o_ext_op = 1'b1;
            end
            c_OP_J:   o_class = CLS_JUMP;
            // A build without jal treats the opcode exactly like any unknown one
            c_OP_JAL: o_class = (EN_JAL != 0) ? CLS_JAL : CLS_ILLEGAL;
            default:  o_class = CLS_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_fsm
//  Brief    : Multi-cycle MIPS-subset control FSM with memory timeout and trap.
//  Revision : 1.0  initial release
// ============================================================================
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int ALUCTRL_W   = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int EN_JAL      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic [5:0]           func,
    input  logic                 zero,
    input  logic                 stall,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 MemWrite,
    output logic                 IorD,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic [1:0]           PC_sel,
    output logic [1:0]           RegDst,
    output logic                 RegWrite,
    output logic [1:0]           DatatoReg,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic                 ExtOp,
    output logic [ALUCTRL_W-1:0] ALUCtrl,
    output logic                 trap,
    output logic                 trap_cause
);

    state_e                 r_state;
    state_e                 w_state_next;
    logic [c_TIMEOUT_W-1:0] r_wait_cnt;
    logic [c_TIMEOUT_W:0]   w_cnt_inc;
    logic                   w_timeout;
    logic                   w_mem_phase;
    logic                   r_trap;
    logic                   r_trap_cause;
    logic                   w_trap_cause_next;
    logic                   w_is_jump;
    logic [c_ALUOP_W-1:0]   w_aluctrl;

    inst_class_e            w_class;
    logic [c_ALUOP_W-1:0]   w_alu_op;
    logic [1:0]             w_alu_srcb;
    logic                   w_ext_op;

    mc_ctrl_decode #(
        .EN_JAL     (EN_JAL)
    ) u_decode (
        .i_opcode   (opcode),
        .i_func     (func),
        .o_class    (w_class),
        .o_alu_op   (w_alu_op),
        .o_alu_srcb (w_alu_srcb),
        .o_ext_op   (w_ext_op)
    );

    // Counter is one extra bit wide so the compare cannot wrap
    assign w_cnt_inc   = {1'b0, r_wait_cnt} + (c_TIMEOUT_W+1)'(1);
    assign w_timeout   = !mem_ready && (w_cnt_inc == (c_TIMEOUT_W+1)'(MEM_TIMEOUT));
    assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_is_jump   = (w_class == CLS_JUMP) || (w_class == CLS_JAL) || (w_class == CLS_JR);
    assign ALUCtrl     = ALUCTRL_W'(w_aluctrl);
    assign trap        = r_trap;
    assign trap_cause  = r_trap_cause;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_RST;
            r_wait_cnt   <= '0;
            r_trap       <= 1'b0;
            r_trap_cause <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state)
                r_wait_cnt <= '0;
            else if (w_mem_phase && !stall && !mem_ready)
                r_wait_cnt <= w_cnt_inc[c_TIMEOUT_W-1:0];
            if ((w_state_next == S_TRAP) && (r_state != S_TRAP)) begin
                r_trap       <= 1'b1;
                r_trap_cause <= w_trap_cause_next;
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_trap_cause_next = c_CAUSE_ILLEGAL;
        mem_req           = 1'b0;
        MemWrite          = 1'b0;
        IorD              = 1'b0;
        IRWrite           = 1'b0;
        PCWrite           = 1'b0;
        PC_sel            = c_PCSEL_SEQ;
        RegDst            = c_REGDST_RT;
        RegWrite          = 1'b0;
        DatatoReg         = c_WD_ALU;
        ALUSrcA           = 1'b0;
        ALUSrcB           = c_SRCB_B;
        ExtOp             = 1'b0;
        w_aluctrl         = c_ALUOP_NOP;
        case (r_state)
            S_RST: w_state_next = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = c_SRCB_FOUR;
                w_aluctrl = c_ALUOP_ADD;
                if (!stall) begin
                    if (mem_ready) begin
                        IRWrite      = 1'b1;
                        PCWrite      = 1'b1;
                        w_state_next = S_DECODE;
                    end else if (w_timeout) begin
                        w_state_next      = S_TRAP;
                        w_trap_cause_next = c_CAUSE_TIMEOUT;
                    end
                end
            end
            S_DECODE: begin
                // ALUOut captures the branch target for a possible EXEC-stage branch
                ALUSrcB   = c_SRCB_IMMSH;
                ExtOp     = 1'b1;
                w_aluctrl = c_ALUOP_ADD;
                if (w_is_jump) begin
                    PC_sel  = (w_class == CLS_JR) ? c_PCSEL_RS : c_PCSEL_JT;
                    PCWrite = !stall;
                end
                if (w_class == CLS_JAL) begin
                    RegDst    = c_REGDST_RA;
                    DatatoReg = c_WD_PC;
                    RegWrite  = !stall;
                end
                if (!stall) begin
                    if (w_class == CLS_ILLEGAL)
                        w_state_next = S_TRAP;
                    else if (w_is_jump)
                        w_state_next = S_FETCH;
                    else
                        w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = w_alu_srcb;
                ExtOp     = w_ext_op;
                w_aluctrl = w_alu_op;
                if (w_class == CLS_BRANCH) begin
                    PC_sel  = c_PCSEL_BR;
                    PCWrite = zero && !stall;
                end
                if (!stall) begin
                    if (w_class == CLS_BRANCH)
                        w_state_next = S_FETCH;
                    else if ((w_class == CLS_LOAD) || (w_class == CLS_STORE))
                        w_state_next = S_MEM;
                    else
                        w_state_next = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = (w_class == CLS_STORE) && !stall;
                if (!stall) begin
                    if (mem_ready) begin
                        w_state_next = (w_class == CLS_STORE) ? S_FETCH : S_WB;
                    end else if (w_timeout) begin
                        w_state_next      = S_TRAP;
                        w_trap_cause_next = c_CAUSE_TIMEOUT;
                    end
                end
            end
            S_WB: begin
                RegWrite = !stall;
                if (w_class == CLS_R_ALU)
                    RegDst = c_REGDST_RD;
                if (w_class == CLS_LOAD)
                    DatatoReg = c_WD_MDR;
                if (!stall)
                    w_state_next = S_FETCH;
            end
            S_TRAP: w_state_next = S_TRAP;
            default: w_state_next = S_RST;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_ctrl_fsm
//  Brief    : Directed vector bench for mc_ctrl_fsm (jal enabled and disabled).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic       zero = 1'b0;
    logic       stall = 1'b0;
    logic       mem_ready = 1'b0;

    logic       mem_req, MemWrite, IorD, IRWrite, PCWrite, RegWrite, ALUSrcA, ExtOp, trap, trap_cause;
    logic [1:0] PC_sel, RegDst, DatatoReg, ALUSrcB;
    logic [4:0] ALUCtrl;

    logic       mem_req_2, MemWrite_2, IorD_2, IRWrite_2, PCWrite_2, RegWrite_2, ALUSrcA_2, ExtOp_2, trap_2, trap_cause_2;
    logic [1:0] PC_sel_2, RegDst_2, DatatoReg_2, ALUSrcB_2;
    logic [4:0] ALUCtrl_2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.ALUCTRL_W(5), .MEM_TIMEOUT(15), .EN_JAL(1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero), .stall(stall),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PC_sel(PC_sel), .RegDst(RegDst),
        .RegWrite(RegWrite), .DatatoReg(DatatoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ExtOp(ExtOp), .ALUCtrl(ALUCtrl), .trap(trap), .trap_cause(trap_cause)
    );

    mc_ctrl_fsm #(.ALUCTRL_W(5), .MEM_TIMEOUT(15), .EN_JAL(0)) dut_nojal (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero), .stall(stall),
        .mem_ready(mem_ready), .mem_req(mem_req_2), .MemWrite(MemWrite_2), .IorD(IorD_2),
        .IRWrite(IRWrite_2), .PCWrite(PCWrite_2), .PC_sel(PC_sel_2), .RegDst(RegDst_2),
        .RegWrite(RegWrite_2), .DatatoReg(DatatoReg_2), .ALUSrcA(ALUSrcA_2), .ALUSrcB(ALUSrcB_2),
        .ExtOp(ExtOp_2), .ALUCtrl(ALUCtrl_2), .trap(trap_2), .trap_cause(trap_cause_2)
    );

    logic [22:0] act;
    assign act = {mem_req, MemWrite, IorD, IRWrite, PCWrite, PC_sel, RegDst, RegWrite,
                  DatatoReg, ALUSrcA, ALUSrcB, ExtOp, ALUCtrl, trap, trap_cause};

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic        stl;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs[$];

    localparam int A_ADDU = 1, A_ADD = 2, A_OR = 6, A_SLT = 7, A_EQL = 8, A_BNE = 9, A_SLL = 10, A_LUI = 13;
    localparam int OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam int OP_SLTI = 6'h0A, OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam int FN_ADDU = 6'h21, FN_SLL = 6'h00, FN_JR = 6'h08;

    // Field order: mem_req MemWrite IorD IRWrite PCWrite PC_sel RegDst RegWrite DatatoReg ALUSrcA ALUSrcB ExtOp ALUCtrl trap trap_cause
    function automatic logic [22:0] pk(input int mreq, mw, iord, irw, pcw, pcsel, rdst, rw,
                                       d2r, sa, sb, ext, alu, tr, tc);
        return {1'(mreq), 1'(mw), 1'(iord), 1'(irw), 1'(pcw), 2'(pcsel), 2'(rdst), 1'(rw),
                2'(d2r), 1'(sa), 2'(sb), 1'(ext), 5'(alu), 1'(tr), 1'(tc)};
    endfunction

    logic [22:0] E0, FG, FW, DC, DC_J, DC_JAL, DC_JR;
    logic [22:0] EX_ADDU, EX_SLL, EX_ORI, EX_SLTI, EX_LUI, EX_MEM, EX_BEQ_T, EX_BEQ_N, EX_BNE_T, EX_BEQ_ST;
    logic [22:0] WB_R, WB_R_ST, WB_I, WB_L, MEM_R, MEM_W, MEM_W_ST, TRAP_ILL, TRAP_TO;

    task automatic chk(input string nm, input logic [22:0] a, input logic [22:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    task automatic add(input int op, fn, z, r, s, input logic [22:0] e);
        vec_t v;
        v.op = 6'(op); v.fn = 6'(fn); v.z = 1'(z); v.rdy = 1'(r); v.stl = 1'(s); v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drv(input int op, fn, z, r, s);
        opcode = 6'(op); func = 6'(fn); zero = 1'(z); mem_ready = 1'(r); stall = 1'(s);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset and consume the S_RST cycle; returns at posedge+1 with FSM in FETCH
    task automatic do_reset();
        drv(0, 0, 0, 0, 0);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        #2 chk("rst_state", act, E0);
        nxt();
    endtask

    initial begin
        E0        = '0;
        FG        = pk(1,0,0,1,1,0,0,0,0,0,1,0,A_ADD,0,0);
        FW        = pk(1,0,0,0,0,0,0,0,0,0,1,0,A_ADD,0,0);
        DC        = pk(0,0,0,0,0,0,0,0,0,0,3,1,A_ADD,0,0);
        DC_J      = pk(0,0,0,0,1,3,0,0,0,0,3,1,A_ADD,0,0);
        DC_JAL    = pk(0,0,0,0,1,3,2,1,2,0,3,1,A_ADD,0,0);
        DC_JR     = pk(0,0,0,0,1,2,0,0,0,0,3,1,A_ADD,0,0);
        EX_ADDU   = pk(0,0,0,0,0,0,0,0,0,1,0,0,A_ADDU,0,0);
        EX_SLL    = pk(0,0,0,0,0,0,0,0,0,1,0,0,A_SLL,0,0);
        EX_ORI    = pk(0,0,0,0,0,0,0,0,0,1,2,0,A_OR,0,0);
        EX_SLTI   = pk(0,0,0,0,0,0,0,0,0,1,2,1,A_SLT,0,0);
        EX_LUI    = pk(0,0,0,0,0,0,0,0,0,1,2,0,A_LUI,0,0);
        EX_MEM    = pk(0,0,0,0,0,0,0,0,0,1,2,1,A_ADDU,0,0);
        EX_BEQ_T  = pk(0,0,0,0,1,1,0,0,0,1,0,1,A_EQL,0,0);
        EX_BEQ_N  = pk(0,0,0,0,0,1,0,0,0,1,0,1,A_EQL,0,0);
        EX_BEQ_ST = EX_BEQ_N;
        EX_BNE_T  = pk(0,0,0,0,1,1,0,0,0,1,0,1,A_BNE,0,0);
        WB_R      = pk(0,0,0,0,0,0,1,1,0,0,0,0,0,0,0);
        WB_R_ST   = pk(0,0,0,0,0,0,1,0,0,0,0,0,0,0,0);
        WB_I      = pk(0,0,0,0,0,0,0,1,0,0,0,0,0,0,0);
        WB_L      = pk(0,0,0,0,0,0,0,1,1,0,0,0,0,0,0);
        MEM_R     = pk(1,0,1,0,0,0,0,0,0,0,0,0,0,0,0);
        MEM_W     = pk(1,1,1,0,0,0,0,0,0,0,0,0,0,0,0);
        MEM_W_ST  = MEM_R;
        TRAP_ILL  = pk(0,0,0,0,0,0,0,0,0,0,0,0,0,1,0);
        TRAP_TO   = pk(0,0,0,0,0,0,0,0,0,0,0,0,0,1,1);

        // op, func, zero, mem_ready, stall, expected
        add(0, 0, 0, 1, 0, E0);
        add(OP_R, FN_ADDU, 0, 1, 0, FG);  add(OP_R, FN_ADDU, 0, 1, 0, DC);
        add(OP_R, FN_ADDU, 0, 1, 0, EX_ADDU); add(OP_R, FN_ADDU, 0, 1, 0, WB_R);
        add(OP_ORI, 0, 0, 1, 0, FG); add(OP_ORI, 0, 0, 1, 0, DC);
        add(OP_ORI, 0, 0, 1, 0, EX_ORI); add(OP_ORI, 0, 0, 1, 0, WB_I);
        add(OP_LW, 0, 0, 1, 0, FG); add(OP_LW, 0, 0, 1, 0, DC); add(OP_LW, 0, 0, 1, 0, EX_MEM);
        add(OP_LW, 0, 0, 0, 0, MEM_R); add(OP_LW, 0, 0, 0, 0, MEM_R); add(OP_LW, 0, 0, 1, 0, MEM_R);
        add(OP_LW, 0, 0, 1, 0, WB_L);
        add(OP_SW, 0, 0, 1, 0, FG); add(OP_SW, 0, 0, 1, 0, DC);
        add(OP_SW, 0, 0, 1, 0, EX_MEM); add(OP_SW, 0, 0, 1, 0, MEM_W);
        add(OP_BEQ, 0, 1, 1, 0, FG); add(OP_BEQ, 0, 1, 1, 0, DC); add(OP_BEQ, 0, 1, 1, 0, EX_BEQ_T);
        add(OP_BEQ, 0, 0, 1, 0, FG); add(OP_BEQ, 0, 0, 1, 0, DC); add(OP_BEQ, 0, 0, 1, 0, EX_BEQ_N);
        add(OP_BNE, 0, 1, 1, 0, FG); add(OP_BNE, 0, 1, 1, 0, DC); add(OP_BNE, 0, 1, 1, 0, EX_BNE_T);
        add(OP_J, 0, 0, 1, 0, FG); add(OP_J, 0, 0, 1, 0, DC_J);
        add(OP_JAL, 0, 0, 1, 0, FG); add(OP_JAL, 0, 0, 1, 0, DC_JAL);
        add(OP_R, FN_JR, 0, 1, 0, FG); add(OP_R, FN_JR, 0, 1, 0, DC_JR);
        add(OP_R, FN_SLL, 0, 1, 0, FG); add(OP_R, FN_SLL, 0, 1, 0, DC);
        add(OP_R, FN_SLL, 0, 1, 0, EX_SLL); add(OP_R, FN_SLL, 0, 1, 0, WB_R);
        add(OP_SLTI, 0, 0, 1, 0, FG); add(OP_SLTI, 0, 0, 1, 0, DC);
        add(OP_SLTI, 0, 0, 1, 0, EX_SLTI); add(OP_SLTI, 0, 0, 1, 0, WB_I);
        add(OP_LUI, 0, 0, 1, 0, FG); add(OP_LUI, 0, 0, 1, 0, DC);
        add(OP_LUI, 0, 0, 1, 0, EX_LUI); add(OP_LUI, 0, 0, 1, 0, WB_I);
        // Wait cycle in FETCH, then a 3-cycle stall in WB
        add(OP_R, FN_ADDU, 0, 0, 0, FW); add(OP_R, FN_ADDU, 0, 1, 0, FG); add(OP_R, FN_ADDU, 0, 1, 0, DC);
        add(OP_R, FN_ADDU, 0, 1, 0, EX_ADDU);
        add(OP_R, FN_ADDU, 0, 1, 1, WB_R_ST); add(OP_R, FN_ADDU, 0, 1, 1, WB_R_ST);
        add(OP_R, FN_ADDU, 0, 1, 1, WB_R_ST); add(OP_R, FN_ADDU, 0, 1, 0, WB_R);
        // Stalled FETCH ignores mem_ready and suppresses IRWrite/PCWrite
        add(OP_SW, 0, 1, 1, 1, FW); add(OP_SW, 0, 1, 1, 0, FG); add(OP_SW, 0, 1, 1, 0, DC);
        add(OP_SW, 0, 1, 1, 0, EX_MEM); add(OP_SW, 0, 1, 1, 1, MEM_W_ST); add(OP_SW, 0, 1, 1, 0, MEM_W);
        add(OP_BEQ, 0, 1, 1, 0, FG); add(OP_BEQ, 0, 1, 1, 0, DC);
        add(OP_BEQ, 0, 1, 1, 1, EX_BEQ_ST); add(OP_BEQ, 0, 1, 1, 0, EX_BEQ_T);
        add(OP_R, FN_ADDU, 0, 1, 0, FG);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", act, E0);
        chk("reset_outputs_nojal", {mem_req_2, trap_2, trap_cause_2, 20'd0}, 23'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drv(int'(vecs[i].op), int'(vecs[i].fn), int'(vecs[i].z), int'(vecs[i].rdy), int'(vecs[i].stl));
            #2 chk($sformatf("vec%0d", i), act, vecs[i].exp);
            nxt();
        end

        // jal with EN_JAL=0 traps as illegal
        do_reset();
        drv(OP_JAL, 0, 0, 1, 0); nxt();
        #2 chk("nojal_decode_pcwrite", 23'({PCWrite_2, RegWrite_2, trap_2}), 23'd0);
        nxt();
        #2 chk("nojal_trap", 23'({trap_2, trap_cause_2, mem_req_2}), 23'b100);

        // Illegal opcode: absorbing TRAP with cause 0
        do_reset();
        drv(6'h3F, 0, 0, 1, 0);
        #2 chk("ill_fetch", act, FG);
        nxt();
        #2 chk("ill_decode", act, DC);
        nxt();
        drv(OP_R, FN_ADDU, 1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            #2 chk($sformatf("ill_trap%0d", k), act, TRAP_ILL);
            nxt();
        end

        // 14 empty cycles then ready on the 15th: completes normally
        do_reset();
        drv(OP_R, FN_ADDU, 0, 0, 0);
        for (int k = 0; k < 14; k++) begin
            #2 chk($sformatf("to_edge_wait%0d", k), act, FW);
            nxt();
        end
        drv(OP_R, FN_ADDU, 0, 1, 0);
        #2 chk("to_edge_ready", act, FG);
        nxt();
        #2 chk("to_edge_decode", act, DC);
        nxt();

        // mem_ready held low in FETCH for 15 cycles: timeout trap
        do_reset();
        drv(OP_R, FN_ADDU, 0, 0, 0);
        for (int k = 0; k < 15; k++) begin
            #2 chk($sformatf("to_wait%0d", k), act, FW);
            nxt();
        end
        drv(OP_R, FN_ADDU, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            #2 chk($sformatf("to_trap%0d", k), act, TRAP_TO);
            nxt();
        end

        // rst asserted mid-EXEC of a taken branch clears every strobe at once
        do_reset();
        drv(OP_BEQ, 0, 1, 1, 0); nxt(); nxt();
        #2 chk("rst_exec_before", act, EX_BEQ_T);
        #1 rst = 1'b1;
        #1 chk("rst_exec_after", act, E0);
        nxt();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
